multi_clock_divider: RTL and testbench

Multi-channel programmable clock-enable generator, the successor to the single-channel power-of-two divider. Each of `NUM_CH` channels divides `clk` by an arbitrary integer (1 to 2^`DIV_W`) and runs in one of three modes: periodic pulse, 50%-duty square, or one-shot. Channels are configured one at a time through a synchronous write port. A global resync input phase-aligns all channels, giving the PWM and peripheral timing logic coherent enables.

---
 rtl/multi_clock_divider.sv | 114 +++++++++++
 tb/tb_multi_clock_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock-enable generator: per-channel integer divide
// with pulse, 50%-duty square and one-shot modes, plus a global phase resync.
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [1:0]        wr_mode,
  input  logic              resync,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DIV_W-1:0]  rd_div,
  output logic [1:0]        rd_mode,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_SQUARE  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_nx [NUM_CH];
  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_nx [NUM_CH];
  mode_e             mode_q [NUM_CH];
  mode_e             mode_nx[NUM_CH];
  logic [NUM_CH-1:0] div_out_nx;
  logic [NUM_CH-1:0] tick_nx;
  logic [NUM_CH-1:0] tc;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_nx[i]     = div_q[i];
      mode_nx[i]    = mode_q[i];
      cnt_nx[i]     = cnt_q[i];
      div_out_nx[i] = div_out[i];
      tick_nx[i]    = 1'b0;
      tc[i]         = (mode_q[i] != MODE_OFF) && (cnt_q[i] == div_q[i]);

      // A write outranks resync, and both outrank any terminal count this cycle.
      if (wr && (wr_ch == CH_W'(i))) begin
        div_nx[i]     = wr_div;
        mode_nx[i]    = mode_e'(wr_mode);
        cnt_nx[i]     = '0;
        div_out_nx[i] = 1'b0;
      end else if (resync) begin
        cnt_nx[i]     = '0;
        div_out_nx[i] = 1'b0;
      end else begin
        cnt_nx[i] = tc[i] ? '0 : cnt_q[i] + DIV_W'(1);
        case (mode_q[i])
          MODE_OFF: begin
            cnt_nx[i]     = '0;
            div_out_nx[i] = 1'b0;
          end
          MODE_PULSE: begin
            div_out_nx[i] = tc[i];
            tick_nx[i]    = tc[i];
          end
          MODE_SQUARE: begin
            if (tc[i]) div_out_nx[i] = ~div_out[i];
            tick_nx[i] = tc[i];
          end
          MODE_ONESHOT: begin
            div_out_nx[i] = tc[i];
            tick_nx[i]    = tc[i];
            if (tc[i]) mode_nx[i] = MODE_OFF;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= '0;
        cnt_q[i]  <= '0;
        mode_q[i] <= MODE_OFF;
      end
      div_out <= '0;
      tick    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_nx[i];
        cnt_q[i]  <= cnt_nx[i];
        mode_q[i] <= mode_nx[i];
      end
      div_out <= div_out_nx;
      tick    <= tick_nx;
    end
  end

  always_comb begin
    rd_div  = '0;
    rd_mode = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_div  = div_q[i];
        rd_mode = mode_q[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider; channel index is
// widened so an out-of-range write/read (channel 4 of 4) is representable.
module tb_multi_clock_divider;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [DIV_W-1:0]  wr_div = '0;
  logic [1:0]        wr_mode = '0;
  logic              resync = 1'b0;
  logic [CH_W-1:0]   rd_ch = '0;
  logic [DIV_W-1:0]  rd_div;
  logic [1:0]        rd_mode;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] tick;

  int errors = 0;
  int checks = 0;

  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_mode(wr_mode), .resync(resync), .rd_ch(rd_ch), .rd_div(rd_div),
    .rd_mode(rd_mode), .div_out(div_out), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int d, input int m);
    wr      = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_div  = DIV_W'(d);
    wr_mode = 2'(m);
    step();
    wr = 1'b0;
  endtask

  task automatic read_cfg(input string tag, input int ch, input int d, input int m);
    rd_ch = CH_W'(ch);
    #1;
    check({tag, "_div"}, 32'(rd_div), 32'(d));
    check({tag, "_mode"}, 32'(rd_mode), 32'(m));
  endtask

  initial begin
    int cnt [NUM_CH];

    // Reset state
    #12;
    check("rst_div_out", 32'(div_out), 0);
    check("rst_tick", 32'(tick), 0);
    for (int c = 0; c < NUM_CH; c++) read_cfg("rst_cfg", c, 0, 0);
    rst = 1'b0;
    step();

    // Pulse D=3: tick 4 cycles after write, then every 4
    write_cfg(0, 3, 1);
    check("pulse_after_wr", 32'(tick[0]), 0);
    read_cfg("pulse_cfg", 0, 3, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("pulse3_tick", 32'(tick[0]), 32'(k % 4 == 0));
      check("pulse3_out", 32'(div_out[0]), 32'(k % 4 == 0));
    end

    // Pulse D=0: constant 1
    write_cfg(0, 0, 1);
    check("pulse0_after_wr", 32'(tick[0]), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("pulse0_tick", 32'(tick[0]), 1);
      check("pulse0_out", 32'(div_out[0]), 1);
    end

    // Square D=2: 3 high / 3 low, first rise 3 cycles after write
    write_cfg(1, 2, 2);
    check("sq2_after_wr", 32'(div_out[1]), 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("sq2_out", 32'(div_out[1]), 32'((k / 3) % 2));
      check("sq2_tick", 32'(tick[1]), 32'(k % 3 == 0));
    end

    // Square D=255: period 512
    write_cfg(1, 255, 2);
    read_cfg("sq255_cfg", 1, 255, 2);
    for (int k = 1; k <= 1024; k++) begin
      step();
      check("sq255_out", 32'(div_out[1]), 32'((k / 256) % 2));
    end

    // One-shot D=5: single tick 6 cycles after write, then off
    write_cfg(2, 5, 3);
    rd_ch = 3'd2;
    for (int k = 1; k <= 106; k++) begin
      step();
      check("os_tick", 32'(tick[2]), 32'(k == 6));
      check("os_out", 32'(div_out[2]), 32'(k == 6));
      check("os_rd_mode", 32'(rd_mode), (k >= 6) ? 0 : 3);
    end

    // Write ch0 exactly on its TC edge: tick suppressed, count restarts
    write_cfg(0, 3, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("coll_pre_tick", 32'(tick[0]), 0);
    end
    write_cfg(0, 3, 1);
    check("coll_tc_tick", 32'(tick[0]), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("coll_post_tick", 32'(tick[0]), 32'(k % 4 == 0));
    end

    // Resync aligns misaligned ch0/ch3 at D=1
    write_cfg(0, 1, 1);
    step();
    write_cfg(3, 1, 1);
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rsync_tick0", 32'(tick[0]), 0);
    check("rsync_tick3", 32'(tick[3]), 0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) begin
        wr = 1'b1; wr_ch = 3'd4; wr_div = 8'h55; wr_mode = 2'd3;
        step();
        wr = 1'b0;
      end else begin
        step();
      end
      check("rsync_t0", 32'(tick[0]), 32'(k % 2 == 0));
      check("rsync_t3", 32'(tick[3]), 32'(k % 2 == 0));
    end

    // Out-of-range write left every channel's config intact
    read_cfg("oor_rd4", 4, 0, 0);
    read_cfg("oor_ch0", 0, 1, 1);
    read_cfg("oor_ch1", 1, 255, 2);
    read_cfg("oor_ch2", 2, 5, 0);
    read_cfg("oor_ch3", 3, 1, 1);

    // Independence: D=0..3 pulse, aligned by resync, counted over 120 cycles
    for (int c = 0; c < NUM_CH; c++) write_cfg(c, c, 1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(tick[c]);
    end
    for (int c = 0; c < NUM_CH; c++) check("indep_count", 32'(cnt[c]), 32'(120 / (c + 1)));

    // Asynchronous reset mid-cycle
    check("pre_rst_tick0", 32'(tick[0]), 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_div_out", 32'(div_out), 0);
    for (int c = 0; c < NUM_CH; c++) read_cfg("mid_rst_cfg", c, 0, 0);
    #2;
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
